// File: rtl/i2c_pkg.sv
// Shared I2C constants: requester count and arbiter state encoding.
// Imported by the request arbiter and its round-robin picker.
package i2c_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot next owner from eligibility.
// On a tie the requester that did not own the bus last wins.
module rr_pick2
  import i2c_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic               last_owner,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    case (elig)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_owner ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-requester arbiter for one I2C master: round-robin grant,
// grant timeout with per-requester blocking, muxed datapath.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int DATA_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  output logic [NUM_REQ-1:0]      o_gnt,
  input  logic [NUM_REQ-1:0]      i_start,
  input  logic [NUM_REQ-1:0]      i_addr_valid,
  input  logic [NUM_REQ-1:0]      i_nbytes_valid,
  input  logic [NUM_REQ-1:0]      i_wdata_valid,
  input  logic [NUM_REQ-1:0]      i_rdata_ready,
  input  logic [2*DATA_DEPTH-1:0] i_addr_bits,
  input  logic [2*DATA_DEPTH-1:0] i_nbytes_bits,
  input  logic [2*DATA_DEPTH-1:0] i_wdata_bits,
  output logic [NUM_REQ-1:0]      o_addr_ready,
  output logic [NUM_REQ-1:0]      o_nbytes_ready,
  output logic [NUM_REQ-1:0]      o_wdata_ready,
  output logic [NUM_REQ-1:0]      o_rdata_valid,
  output logic [NUM_REQ-1:0]      o_nak,
  output logic [DATA_DEPTH-1:0]   o_rdata_bits,
  output logic                    o_m_start,
  output logic                    o_m_addr_valid,
  output logic                    o_m_nbytes_valid,
  output logic                    o_m_wdata_valid,
  output logic                    o_m_rdata_ready,
  input  logic                    i_m_addr_ready,
  input  logic                    i_m_nbytes_ready,
  input  logic                    i_m_wdata_ready,
  input  logic                    i_m_rdata_valid,
  input  logic                    i_m_nak,
  output logic [DATA_DEPTH-1:0]   o_m_addr_bits,
  output logic [DATA_DEPTH-1:0]   o_m_nbytes_bits,
  output logic [DATA_DEPTH-1:0]   o_m_wdata_bits,
  input  logic [DATA_DEPTH-1:0]   i_m_rdata_bits,
  output logic                    o_busy,
  output logic                    o_timeout,
  output logic                    o_timeout_id
);

  localparam int DW = DATA_DEPTH;
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t        state, state_n;
  logic [NUM_REQ-1:0] gnt_n, blk, blk_n, pick;
  logic [15:0]       cnt, cnt_n;
  logic              last_owner, last_n;
  logic              owner, owner_n;
  logic              timeout_n, toid_n;

  rr_pick2 u_pick (
    .elig       (i_req & ~blk),
    .last_owner (last_owner),
    .pick       (pick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_gnt        <= '0;
      cnt          <= '0;
      blk          <= '0;
      last_owner   <= 1'b1;
      owner        <= 1'b0;
      o_timeout    <= 1'b0;
      o_timeout_id <= 1'b0;
    end else begin
      state        <= state_n;
      o_gnt        <= gnt_n;
      cnt          <= cnt_n;
      blk          <= blk_n;
      last_owner   <= last_n;
      owner        <= owner_n;
      o_timeout    <= timeout_n;
      o_timeout_id <= toid_n;
    end
  end

  // Block bits clear as soon as the requester lets go of i_req.
  always_comb begin
    state_n   = state;
    gnt_n     = o_gnt;
    cnt_n     = cnt;
    blk_n     = blk & i_req;
    last_n    = last_owner;
    owner_n   = owner;
    timeout_n = 1'b0;
    toid_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pick) begin
          state_n = ST_GRANT;
          gnt_n   = pick;
          owner_n = pick[1];
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (!i_req[owner]) begin
          state_n = ST_RELEASE;
          gnt_n   = '0;
        end else if (cnt >= CNT_MAX) begin
          state_n       = ST_RELEASE;
          gnt_n         = '0;
          timeout_n     = 1'b1;
          toid_n        = owner;
          blk_n[owner]  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
        last_n  = owner;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

  // o_gnt is one-hot or zero, so AND-OR muxing needs no owner decode.
  assign o_m_start        = |(o_gnt & i_start);
  assign o_m_addr_valid   = |(o_gnt & i_addr_valid);
  assign o_m_nbytes_valid = |(o_gnt & i_nbytes_valid);
  assign o_m_wdata_valid  = |(o_gnt & i_wdata_valid);
  assign o_m_rdata_ready  = |(o_gnt & i_rdata_ready);

  assign o_m_addr_bits =
    ({DW{o_gnt[0]}} & i_addr_bits[DW-1:0]) |
    ({DW{o_gnt[1]}} & i_addr_bits[2*DW-1:DW]);
  assign o_m_nbytes_bits =
    ({DW{o_gnt[0]}} & i_nbytes_bits[DW-1:0]) |
    ({DW{o_gnt[1]}} & i_nbytes_bits[2*DW-1:DW]);
  assign o_m_wdata_bits =
    ({DW{o_gnt[0]}} & i_wdata_bits[DW-1:0]) |
    ({DW{o_gnt[1]}} & i_wdata_bits[2*DW-1:DW]);

  assign o_addr_ready   = o_gnt & {NUM_REQ{i_m_addr_ready}};
  assign o_nbytes_ready = o_gnt & {NUM_REQ{i_m_nbytes_ready}};
  assign o_wdata_ready  = o_gnt & {NUM_REQ{i_m_wdata_ready}};
  assign o_rdata_valid  = o_gnt & {NUM_REQ{i_m_rdata_valid}};
  assign o_nak          = o_gnt & {NUM_REQ{i_m_nak}};
  assign o_rdata_bits   = i_m_rdata_bits;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus random traffic
// checked by a scoreboard fed from a grant-episode reference model.
module tb_i2c_req_arbiter;

  localparam int DW = 8;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] i_req, o_gnt;
  logic [1:0] i_start, i_addr_valid, i_nbytes_valid;
  logic [1:0] i_wdata_valid, i_rdata_ready;
  logic [2*DW-1:0] i_addr_bits, i_nbytes_bits, i_wdata_bits;
  logic [1:0] o_addr_ready, o_nbytes_ready, o_wdata_ready;
  logic [1:0] o_rdata_valid, o_nak;
  logic [DW-1:0] o_rdata_bits;
  logic o_m_start, o_m_addr_valid, o_m_nbytes_valid;
  logic o_m_wdata_valid, o_m_rdata_ready;
  logic i_m_addr_ready, i_m_nbytes_ready, i_m_wdata_ready;
  logic i_m_rdata_valid, i_m_nak;
  logic [DW-1:0] o_m_addr_bits, o_m_nbytes_bits, o_m_wdata_bits;
  logic [DW-1:0] i_m_rdata_bits;
  logic o_busy, o_timeout, o_timeout_id;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.DATA_DEPTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .o_gnt(o_gnt),
    .i_start(i_start), .i_addr_valid(i_addr_valid),
    .i_nbytes_valid(i_nbytes_valid), .i_wdata_valid(i_wdata_valid),
    .i_rdata_ready(i_rdata_ready), .i_addr_bits(i_addr_bits),
    .i_nbytes_bits(i_nbytes_bits), .i_wdata_bits(i_wdata_bits),
    .o_addr_ready(o_addr_ready), .o_nbytes_ready(o_nbytes_ready),
    .o_wdata_ready(o_wdata_ready), .o_rdata_valid(o_rdata_valid),
    .o_nak(o_nak), .o_rdata_bits(o_rdata_bits),
    .o_m_start(o_m_start), .o_m_addr_valid(o_m_addr_valid),
    .o_m_nbytes_valid(o_m_nbytes_valid),
    .o_m_wdata_valid(o_m_wdata_valid),
    .o_m_rdata_ready(o_m_rdata_ready),
    .i_m_addr_ready(i_m_addr_ready),
    .i_m_nbytes_ready(i_m_nbytes_ready),
    .i_m_wdata_ready(i_m_wdata_ready),
    .i_m_rdata_valid(i_m_rdata_valid), .i_m_nak(i_m_nak),
    .o_m_addr_bits(o_m_addr_bits), .o_m_nbytes_bits(o_m_nbytes_bits),
    .o_m_wdata_bits(o_m_wdata_bits), .i_m_rdata_bits(i_m_rdata_bits),
    .o_busy(o_busy), .o_timeout(o_timeout),
    .o_timeout_id(o_timeout_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]      gnt;
    logic            busy;
    logic            to;
    logic            toid;
    logic [4:0]      mctl;
    logic [3*DW-1:0] mbits;
    logic [9:0]      ret;
    logic [DW-1:0]   rd;
  } exp_t;

  exp_t expq[$];

  // Reference model: owner (-1 = none), pending one-cycle release gap.
  int m_own = -1;
  int m_relown = 0;
  int m_cnt = 0;
  int m_last = 1;
  int m_toid = 0;
  bit m_rel = 0;
  bit m_to = 0;
  bit [1:0] m_blk = 0;

  always @(posedge clk or posedge rst) begin : model
    bit [1:0] el;
    if (rst) begin
      m_own = -1; m_rel = 0; m_cnt = 0; m_last = 1;
      m_to = 0; m_toid = 0; m_blk = 0;
    end else begin
      el = i_req & ~m_blk;
      m_blk = m_blk & i_req;
      m_to = 0;
      m_toid = 0;
      if (m_rel) begin
        m_last = m_relown;
        m_rel = 0;
      end else if (m_own < 0) begin
        if (el == 2'b11) m_own = 1 - m_last;
        else if (el == 2'b01) m_own = 0;
        else if (el == 2'b10) m_own = 1;
        m_cnt = 0;
      end else if (!i_req[m_own]) begin
        m_rel = 1; m_relown = m_own; m_own = -1;
      end else if (m_cnt == T - 1) begin
        m_rel = 1; m_relown = m_own; m_to = 1; m_toid = m_own;
        m_blk[m_own] = 1'b1; m_own = -1;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin : predict
    exp_t e;
    int o;
    e.gnt = (m_own >= 0) ? 2'(1 << m_own) : 2'b00;
    e.busy = (m_own >= 0) || m_rel;
    e.to = m_to;
    e.toid = m_toid[0];
    e.rd = i_m_rdata_bits;
    e.mctl = '0;
    e.mbits = '0;
    e.ret = '0;
    if (m_own >= 0) begin
      o = m_own;
      e.mctl = {i_start[o], i_addr_valid[o], i_nbytes_valid[o],
                i_wdata_valid[o], i_rdata_ready[o]};
      e.mbits = {i_addr_bits[o*DW +: DW], i_nbytes_bits[o*DW +: DW],
                 i_wdata_bits[o*DW +: DW]};
      e.ret = {2'({1'b0, i_m_addr_ready} << o),
               2'({1'b0, i_m_nbytes_ready} << o),
               2'({1'b0, i_m_wdata_ready} << o),
               2'({1'b0, i_m_rdata_valid} << o),
               2'({1'b0, i_m_nak} << o)};
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sb_gnt", 64'(o_gnt), 64'(e.gnt));
      chk("sb_busy", 64'(o_busy), 64'(e.busy));
      chk("sb_timeout", 64'(o_timeout), 64'(e.to));
      if (e.to) chk("sb_toid", 64'(o_timeout_id), 64'(e.toid));
      chk("sb_mctl", 64'({o_m_start, o_m_addr_valid, o_m_nbytes_valid,
                          o_m_wdata_valid, o_m_rdata_ready}), 64'(e.mctl));
      chk("sb_mbits", 64'({o_m_addr_bits, o_m_nbytes_bits,
                           o_m_wdata_bits}), 64'(e.mbits));
      chk("sb_ret", 64'({o_addr_ready, o_nbytes_ready, o_wdata_ready,
                         o_rdata_valid, o_nak}), 64'(e.ret));
      chk("sb_rdata", 64'(o_rdata_bits), 64'(e.rd));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_req = 0; i_start = 0; i_addr_valid = 0; i_nbytes_valid = 0;
    i_wdata_valid = 0; i_rdata_ready = 0; i_addr_bits = 0;
    i_nbytes_bits = 0; i_wdata_bits = 0; i_m_addr_ready = 0;
    i_m_nbytes_ready = 0; i_m_wdata_ready = 0; i_m_rdata_valid = 0;
    i_m_nak = 0; i_m_rdata_bits = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin : main
    int n;
    int nb;
    clear_in();
    rst = 1;
    step();
    step();
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    rst = 0;
    step();

    i_req = 2'b01;
    i_addr_bits[7:0] = 8'hA0;
    i_addr_valid = 2'b01;
    i_m_addr_ready = 1;
    step();
    chk("single_gnt", 64'(o_gnt), 64'h1);
    chk("single_addr", 64'(o_m_addr_bits), 64'hA0);
    chk("single_addr_v", 64'(o_m_addr_valid), 64'h1);
    chk("single_rdy", 64'(o_addr_ready), 64'h1);
    clear_in();
    step();
    step();

    do_reset();
    i_req = 2'b11;
    step();
    chk("tie_gnt0", 64'(o_gnt), 64'h1);
    i_req = 2'b10;
    step();
    chk("tie_release", 64'(o_gnt), 64'h0);
    chk("tie_rel_busy", 64'(o_busy), 64'h1);
    step();
    chk("tie_idle", 64'(o_gnt), 64'h0);
    step();
    chk("tie_gnt1", 64'(o_gnt), 64'h2);

    i_m_nak = 1;
    i_m_rdata_valid = 1;
    i_m_rdata_bits = 8'h5C;
    #1;
    chk("own1_nak", 64'(o_nak), 64'h2);
    chk("own1_rvalid", 64'(o_rdata_valid), 64'h2);
    chk("own1_rdata", 64'(o_rdata_bits), 64'h5C);
    clear_in();
    step();
    step();

    do_reset();
    i_req = 2'b01;
    step();
    n = 0;
    for (int i = 0; i < 20 && o_gnt == 2'b01; i++) begin
      n++;
      step();
    end
    chk("to_len", 64'(n), 64'(T));
    chk("to_pulse", 64'(o_timeout), 64'h1);
    chk("to_id", 64'(o_timeout_id), 64'h0);
    nb = 0;
    repeat (10) begin
      step();
      if (o_gnt != 2'b00) nb++;
    end
    chk("to_blocked", 64'(nb), 64'h0);
    i_req = 2'b00;
    step();
    i_req = 2'b01;
    step();
    chk("to_regrant", 64'(o_gnt), 64'h1);
    clear_in();
    step();
    step();

    do_reset();
    i_req = 2'b01;
    i_addr_valid = 2'b01;
    step();
    chk("mid_gnt", 64'(o_gnt), 64'h1);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_gnt", 64'(o_gnt), 64'h0);
    chk("mid_rst_av", 64'(o_m_addr_valid), 64'h0);
    clear_in();
    step();
    rst = 0;
    step();
    chk("mid_busy", 64'(o_busy), 64'h0);

    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(5) == 0) i_req[k] = ~i_req[k];
      i_start = 2'($urandom);
      i_addr_valid = 2'($urandom);
      i_nbytes_valid = 2'($urandom);
      i_wdata_valid = 2'($urandom);
      i_rdata_ready = 2'($urandom);
      i_addr_bits = 16'($urandom);
      i_nbytes_bits = 16'($urandom);
      i_wdata_bits = 16'($urandom);
      i_m_addr_ready = 1'($urandom);
      i_m_nbytes_ready = 1'($urandom);
      i_m_wdata_ready = 1'($urandom);
      i_m_rdata_valid = 1'($urandom);
      i_m_nak = 1'($urandom);
      i_m_rdata_bits = 8'($urandom);
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
